// File: rtl/gps_acq_scheduler.sv
// GPS acquisition scheduler: sweeps SV x Doppler bins through an external
// correlator, confirms candidate peaks with repeated dwells, and reports locks.
module gps_acq_scheduler #(
    parameter int          NUM_SV      = 32,
    parameter int          DOP_BINS    = 21,
    parameter int          DOP_STEP    = 500,
    parameter logic [15:0] PEAK_THRESH = 16'd4000,
    parameter int          CONFIRM_N   = 2,
    parameter int          DWELL_MAX   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        corr_req,
    input  logic        corr_ack,
    output logic [5:0]  corr_sv_id,
    output logic [15:0] corr_doppler,
    input  logic        corr_done,
    input  logic [15:0] corr_peak,
    input  logic [9:0]  corr_code_phase,
    output logic [2:0]  state,
    output logic        busy,
    output logic        lock_valid,
    output logic [31:0] lock_status,
    output logic [5:0]  lock_count,
    output logic        sweep_done
);

    typedef enum logic [2:0] {
        ACQ_IDLE    = 3'b000,
        ACQ_SEARCH  = 3'b001,
        ACQ_CONFIRM = 3'b010,
        ACQ_LOCKED  = 3'b011,
        ACQ_TIMEOUT = 3'b100
    } acq_state_e;

    typedef struct packed {
        logic [5:0]  sv_id;
        logic [15:0] doppler_hz;
        logic [9:0]  code_phase;
    } sat_status_s;

    localparam int BW      = (DOP_BINS > 1) ? $clog2(DOP_BINS) : 1;
    localparam int CW      = $clog2(CONFIRM_N + 1);
    localparam int WW      = $clog2(DWELL_MAX + 1);
    localparam int DOP_MIN = -((DOP_BINS - 1) / 2) * DOP_STEP;

    acq_state_e    r_state, w_next;
    logic [5:0]    r_sv;
    logic [BW-1:0] r_bin;
    logic [CW-1:0] r_conf;
    logic [9:0]    r_cap;
    logic          r_req, r_wait;
    logic [WW-1:0] r_wdog;
    logic [15:0]   r_dop;
    logic          r_lock_valid, r_sweep_done;
    sat_status_s   r_lock_status;
    logic [5:0]    r_lock_count;

    logic          w_expired, w_result, w_peak_ok, w_phase_ok;
    logic [9:0]    w_diff;
    logic          w_last_bin, w_last_sv, w_adv_end;
    logic [5:0]    w_adv_sv, w_nsv;
    logic [BW-1:0] w_adv_bin, w_nbin;
    logic [15:0]   w_ndop;
    logic          w_new_dwell, w_sweep_end, w_capture, w_conf_clr, w_conf_inc;
    logic          w_lock, w_restart;

    // A dwell ends on corr_done, or as a zero-peak failure when the watchdog expires.
    assign w_expired  = r_wait && !corr_done && (r_wdog == WW'(DWELL_MAX - 1));
    assign w_result   = r_wait && (corr_done || w_expired);
    assign w_peak_ok  = corr_done && (corr_peak >= PEAK_THRESH);
    // Code phase wraps at 1023 chips, so 0 and 1022 count as neighbours.
    assign w_diff     = (corr_code_phase >= r_cap) ? (corr_code_phase - r_cap)
                                                   : (r_cap - corr_code_phase);
    assign w_phase_ok = (w_diff <= 10'd1) || (w_diff >= 10'd1022);

    assign w_last_bin = (r_bin == BW'(DOP_BINS - 1));
    assign w_last_sv  = (r_sv == 6'(NUM_SV));
    assign w_adv_sv   = w_last_bin ? 6'(r_sv + 6'd1) : r_sv;
    assign w_adv_bin  = w_last_bin ? '0 : BW'(r_bin + BW'(1));
    assign w_adv_end  = w_last_bin && w_last_sv;
    assign w_ndop     = 16'(DOP_MIN + int'(w_nbin) * DOP_STEP);

    assign state        = r_state;
    assign busy         = (r_state == ACQ_SEARCH) || (r_state == ACQ_CONFIRM) ||
                          (r_state == ACQ_LOCKED);
    assign corr_req     = r_req;
    assign corr_sv_id   = r_sv;
    assign corr_doppler = r_dop;
    assign lock_valid   = r_lock_valid;
    assign lock_status  = r_lock_status;
    assign lock_count   = r_lock_count;
    assign sweep_done   = r_sweep_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACQ_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus one-cycle strobes steering the datapath.
    always_comb begin
        w_next      = r_state;
        w_nsv       = r_sv;
        w_nbin      = r_bin;
        w_new_dwell = 1'b0;
        w_sweep_end = 1'b0;
        w_capture   = 1'b0;
        w_conf_clr  = 1'b0;
        w_conf_inc  = 1'b0;
        w_lock      = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ACQ_IDLE, ACQ_TIMEOUT: begin
                if (start) begin
                    w_next      = ACQ_SEARCH;
                    w_nsv       = 6'd1;
                    w_nbin      = '0;
                    w_new_dwell = 1'b1;
                    w_restart   = 1'b1;
                end
            end
            ACQ_SEARCH, ACQ_CONFIRM: begin
                if (w_result) begin
                    if (r_state == ACQ_SEARCH && w_peak_ok) begin
                        w_next      = ACQ_CONFIRM;
                        w_capture   = 1'b1;
                        w_conf_clr  = 1'b1;
                        w_new_dwell = 1'b1;
                    end else if (r_state == ACQ_CONFIRM && w_peak_ok && w_phase_ok) begin
                        if (r_conf == CW'(CONFIRM_N - 1)) begin
                            w_next = ACQ_LOCKED;
                            w_lock = 1'b1;
                        end else begin
                            w_conf_inc  = 1'b1;
                            w_new_dwell = 1'b1;
                        end
                    end else if (w_adv_end) begin
                        w_sweep_end = 1'b1;
                    end else begin
                        w_next      = ACQ_SEARCH;
                        w_nsv       = w_adv_sv;
                        w_nbin      = w_adv_bin;
                        w_new_dwell = 1'b1;
                    end
                end
            end
            ACQ_LOCKED: begin
                // Remaining bins of a locked SV are not searched.
                if (w_last_sv) begin
                    w_sweep_end = 1'b1;
                end else begin
                    w_next      = ACQ_SEARCH;
                    w_nsv       = 6'(r_sv + 6'd1);
                    w_nbin      = '0;
                    w_new_dwell = 1'b1;
                end
            end
            default: w_next = ACQ_IDLE;
        endcase
        if (w_sweep_end)
            w_next = (r_lock_count != 6'd0) ? ACQ_IDLE : ACQ_TIMEOUT;
        if (abort) begin
            w_next      = ACQ_IDLE;
            w_new_dwell = 1'b0;
            w_sweep_end = 1'b0;
            w_capture   = 1'b0;
            w_conf_clr  = 1'b0;
            w_conf_inc  = 1'b0;
            w_lock      = 1'b0;
            w_restart   = 1'b0;
        end
    end

    // Dwell handshake, watchdog and sweep position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_wait <= 1'b0;
            r_wdog <= '0;
            r_sv   <= 6'd0;
            r_bin  <= '0;
            r_dop  <= 16'd0;
        end else if (abort || w_sweep_end) begin
            r_req  <= 1'b0;
            r_wait <= 1'b0;
        end else if (w_new_dwell) begin
            r_req  <= 1'b1;
            r_wait <= 1'b0;
            r_sv   <= w_nsv;
            r_bin  <= w_nbin;
            r_dop  <= w_ndop;
        end else if (r_req && corr_ack) begin
            r_req  <= 1'b0;
            r_wait <= 1'b1;
            r_wdog <= '0;
        end else if (w_result) begin
            r_wait <= 1'b0;
        end else if (r_wait) begin
            r_wdog <= WW'(r_wdog + WW'(1));
        end
    end

    // Candidate capture, confirm counting and lock reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap         <= 10'd0;
            r_conf        <= '0;
            r_lock_valid  <= 1'b0;
            r_lock_status <= '0;
            r_lock_count  <= 6'd0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_lock_valid <= w_lock;
            r_sweep_done <= w_sweep_end;
            if (w_capture) r_cap <= corr_code_phase;
            if (w_conf_clr)      r_conf <= '0;
            else if (w_conf_inc) r_conf <= CW'(r_conf + CW'(1));
            if (w_lock) r_lock_status <= '{sv_id: r_sv, doppler_hz: r_dop, code_phase: r_cap};
            if (w_restart)
                r_lock_count <= 6'd0;
            else if (w_lock && r_lock_count != 6'd63)
                r_lock_count <= 6'(r_lock_count + 6'd1);
        end
    end

endmodule

// File: tb/tb_gps_acq_scheduler.sv
// Directed bench for gps_acq_scheduler: expected dwells and locks are queued
// ahead of time, and the correlator stand-in pops them as the DUT requests.
module tb_gps_acq_scheduler;

    logic        clk, rst, start, abort;
    logic        corr_req, corr_ack, corr_done;
    logic [5:0]  corr_sv_id;
    logic [15:0] corr_doppler, corr_peak;
    logic [9:0]  corr_code_phase;
    logic [2:0]  state;
    logic        busy, lock_valid, sweep_done;
    logic [31:0] lock_status;
    logic [5:0]  lock_count;

    typedef struct {
        logic [5:0]  sv;
        logic [15:0] dop;
        logic [15:0] peak;
        logic [9:0]  phase;
        int          ack_dly;
        bit          done;
    } dwell_t;

    dwell_t      exp_q[$];
    logic [31:0] lock_q[$];
    logic [31:0] last_lock;
    int          checks = 0;
    int          failures = 0;

    gps_acq_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .corr_req(corr_req), .corr_ack(corr_ack), .corr_sv_id(corr_sv_id),
        .corr_doppler(corr_doppler), .corr_done(corr_done), .corr_peak(corr_peak),
        .corr_code_phase(corr_code_phase), .state(state), .busy(busy),
        .lock_valid(lock_valid), .lock_status(lock_status), .lock_count(lock_count),
        .sweep_done(sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dopv(input int bin);
        return 16'(-5000 + 500 * bin);
    endfunction

    task automatic push(input int sv, input int bin, input int peak, input int phase,
                        input int dly, input bit done);
        dwell_t d;
        d.sv = 6'(sv); d.dop = dopv(bin); d.peak = 16'(peak); d.phase = 10'(phase);
        d.ack_dly = dly; d.done = done;
        exp_q.push_back(d);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!corr_req && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, corr_req}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {29'd0, state}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_req"}, {31'd0, corr_req}, 32'd0);
        check({tag, "_sv"}, {26'd0, corr_sv_id}, 32'd0);
        check({tag, "_dop"}, {16'd0, corr_doppler}, 32'd0);
        check({tag, "_lockv"}, {31'd0, lock_valid}, 32'd0);
        check({tag, "_locks"}, lock_status, 32'd0);
        check({tag, "_lockc"}, {26'd0, lock_count}, 32'd0);
        check({tag, "_sweep"}, {31'd0, sweep_done}, 32'd0);
    endtask

    // Serve every queued dwell: check the request, ack, then answer or stall.
    task automatic run_q();
        dwell_t d;
        int n;
        while (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            wait_req();
            check("sv", {26'd0, corr_sv_id}, {26'd0, d.sv});
            check("dop", {16'd0, corr_doppler}, {16'd0, d.dop});
            if (d.ack_dly > 0) begin
                // A done pulse before the ack must not count as a result.
                corr_done = 1'b1; corr_peak = 16'hffff;
            end
            for (int i = 0; i < d.ack_dly; i++) begin
                @(negedge clk);
                corr_done = 1'b0; corr_peak = 16'd0;
                check("req_hold", {31'd0, corr_req}, 32'd1);
                check("sv_hold", {26'd0, corr_sv_id}, {26'd0, d.sv});
                check("dop_hold", {16'd0, corr_doppler}, {16'd0, d.dop});
            end
            corr_ack = 1'b1;
            @(negedge clk);
            corr_ack = 1'b0;
            check("req_drop", {31'd0, corr_req}, 32'd0);
            if (d.done) begin
                corr_done = 1'b1; corr_peak = d.peak; corr_code_phase = d.phase;
                @(negedge clk);
                corr_done = 1'b0; corr_peak = 16'd0;
            end else begin
                n = 0;
                while (!corr_req && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                check("wdog_cycles", n, 32'd4096);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        corr_ack = 1'b0; corr_done = 1'b0; corr_peak = 16'd0; corr_code_phase = 10'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {29'd0, state}, 32'd0);

        // Full empty sweep ends in TIMEOUT.
        for (int sv = 1; sv <= 32; sv++)
            for (int b = 0; b < 21; b++) push(sv, b, 0, 0, 0, 1'b1);
        pulse_start();
        check("busy_search", {31'd0, busy}, 32'd1);
        run_q();
        check("sweep1_pulse", {31'd0, sweep_done}, 32'd1);
        check("sweep1_state", {29'd0, state}, 32'd4);
        check("sweep1_busy", {31'd0, busy}, 32'd0);
        check("sweep1_lockc", {26'd0, lock_count}, 32'd0);
        @(negedge clk);
        check("sweep1_pulse_end", {31'd0, sweep_done}, 32'd0);
        check("timeout_hold", {29'd0, state}, 32'd4);

        // Lock at sv 3, bin 10, then skip to sv 4.
        for (int sv = 1; sv <= 2; sv++)
            for (int b = 0; b < 21; b++) push(sv, b, 0, 0, 0, 1'b1);
        for (int b = 0; b < 10; b++) push(3, b, 0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) push(3, 10, 5000, 511, 0, 1'b1);
        lock_q.push_back({6'd3, 16'd0, 10'd511});
        pulse_start();
        run_q();
        last_lock = lock_q.pop_front();
        check("lock1_state", {29'd0, state}, 32'd3);
        check("lock1_valid", {31'd0, lock_valid}, 32'd1);
        check("lock1_status", lock_status, last_lock);
        check("lock1_count", {26'd0, lock_count}, 32'd1);
        for (int sv = 4; sv <= 32; sv++)
            for (int b = 0; b < 21; b++) push(sv, b, 0, 0, 0, 1'b1);
        @(negedge clk);
        check("lock1_pulse_end", {31'd0, lock_valid}, 32'd0);
        check("after_lock_state", {29'd0, state}, 32'd1);
        run_q();
        check("sweep2_pulse", {31'd0, sweep_done}, 32'd1);
        check("sweep2_state", {29'd0, state}, 32'd0);
        check("sweep2_lockc", {26'd0, lock_count}, 32'd1);
        check("lock_status_held", lock_status, last_lock);

        // Wrap-adjacent confirm passes, distant one fails.
        push(1, 0, 5000, 0, 0, 1'b1);
        push(1, 0, 5000, 1022, 0, 1'b1);
        push(1, 0, 5000, 5, 0, 1'b1);
        pulse_start();
        run_q();
        check("cfail_state", {29'd0, state}, 32'd1);
        check("cfail_nolock", {31'd0, lock_valid}, 32'd0);
        check("restart_lockc", {26'd0, lock_count}, 32'd0);
        // Slow ack + missing done, then a lock with peak exactly at threshold.
        push(1, 1, 0, 0, 7, 1'b0);
        push(1, 2, 5000, 100, 0, 1'b1);
        push(1, 2, 5000, 101, 0, 1'b1);
        push(1, 2, 4000, 99, 0, 1'b1);
        lock_q.push_back({6'd1, dopv(2), 10'd100});
        run_q();
        last_lock = lock_q.pop_front();
        check("lock2_valid", {31'd0, lock_valid}, 32'd1);
        check("lock2_status", lock_status, last_lock);
        check("lock2_count", {26'd0, lock_count}, 32'd1);

        // Abort together with start while confirming.
        push(2, 0, 6000, 7, 0, 1'b1);
        run_q();
        wait_req();
        check("conf_sv", {26'd0, corr_sv_id}, 32'd2);
        corr_ack = 1'b1;
        @(negedge clk);
        corr_ack = 1'b0;
        check("conf_state", {29'd0, state}, 32'd2);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_req", {31'd0, corr_req}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_lockc", {26'd0, lock_count}, 32'd1);
        check("abort_locks", lock_status, last_lock);
        corr_done = 1'b1; corr_peak = 16'd5000; corr_code_phase = 10'd7;
        @(negedge clk);
        corr_done = 1'b0; corr_peak = 16'd0;
        check("stale_done_state", {29'd0, state}, 32'd0);
        check("stale_done_lockv", {31'd0, lock_valid}, 32'd0);

        // Start mid-dwell is ignored; reset mid-dwell clears outputs at once.
        pulse_start();
        wait_req();
        corr_ack = 1'b1;
        @(negedge clk);
        corr_ack = 1'b0;
        pulse_start();
        check("start_ignored_state", {29'd0, state}, 32'd1);
        check("start_ignored_req", {31'd0, corr_req}, 32'd0);
        check("pre_rst_sv", {26'd0, corr_sv_id}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_state", {29'd0, state}, 32'd0);
        check("post_rst_req", {31'd0, corr_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_acq_scheduler.md
GPS_ACQ_SCHEDULER -- requirements
Module: gps_acq_scheduler

Interface
REQ-001 Parameter NUM_SV, default 32: satellites swept, SV IDs 1..NUM_SV.
REQ-002 Parameter DOP_BINS, default 21: Doppler bins per SV.
REQ-003 Parameter DOP_STEP, default 500: bin spacing, Hz.
REQ-004 Parameter PEAK_THRESH, default 16'd4000: detection threshold on correlator peak.
REQ-005 Parameter CONFIRM_N, default 2: consecutive re-dwells required to confirm.
REQ-006 Parameter DWELL_MAX, default 4096: watchdog cycles per dwell.
REQ-007 Ports: clk in 1, the single clock; rst in 1, asynchronous, active-high.
REQ-008 Ports: start in 1, begin sweep; abort in 1, return to idle.
REQ-009 Ports: corr_req out 1; corr_ack in 1; corr_sv_id out 6; corr_doppler out 16, two's complement Hz.
REQ-010 Ports: corr_done in 1, dwell complete; corr_peak in 16, unsigned; corr_code_phase in 10.
REQ-011 Ports: state out 3, acq_state_e encoding; busy out 1; lock_valid out 1; lock_status out 32, sat_status_s packing {sv_id, doppler_hz, code_phase}; lock_count out 6; sweep_done out 1.

Function
REQ-012 States: ACQ_IDLE, ACQ_SEARCH, ACQ_CONFIRM, ACQ_LOCKED, ACQ_TIMEOUT, encoded 000, 001, 010, 011, 100.
REQ-013 IDLE: start=1 -> SEARCH next cycle, sv=1, bin=0, lock_count=0.
REQ-014 corr_doppler = -(DOP_BINS-1)/2*DOP_STEP + bin*DOP_STEP, 16-bit two's complement; defaults give -5000..+5000.
REQ-015 Dwell handshake: corr_req raised on entry to a dwell, held until the cycle corr_ack=1, then deasserted.
REQ-016 corr_sv_id and corr_doppler are stable while corr_req=1.
REQ-017 After ack, the dwell waits for corr_done; corr_done while corr_req=1 or outside a dwell is ignored.
REQ-018 Watchdog: DWELL_MAX cycles from ack without corr_done is a failed dwell (peak treated as 0).
REQ-019 SEARCH pass: corr_peak >= PEAK_THRESH -> CONFIRM; capture code_phase, confirm counter=0.
REQ-020 SEARCH fail: bin+1; at last bin, bin=0 and sv+1; at last SV, sweep ends (REQ-025).
REQ-021 CONFIRM re-dwells the same sv/bin; pass = peak >= PEAK_THRESH and |code_phase - captured| <= 1 chip, modulo 1023 (0 and 1022 are adjacent).
REQ-022 CONFIRM_N consecutive passes -> LOCKED; any fail -> SEARCH at next bin, with the same advance rule as REQ-020.
REQ-023 LOCKED lasts exactly one cycle: lock_valid=1; lock_status = {sv, corr_doppler, captured code_phase}; lock_count+1, saturating at 63.
REQ-024 After LOCKED: the remaining bins of that SV are skipped; SEARCH continues at sv+1, bin=0, or the sweep ends if sv was last.
REQ-025 Sweep end: sweep_done pulses one cycle; lock_count>0 -> IDLE, else -> TIMEOUT.
REQ-026 TIMEOUT holds until start (restart as in REQ-013) or abort (-> IDLE).
REQ-027 abort=1 in any state -> IDLE next cycle; corr_req drops the same edge; the in-flight dwell result is discarded; lock_count is retained.
REQ-028 abort and start in the same cycle: abort wins.
REQ-029 start outside IDLE/TIMEOUT is ignored.
REQ-030 busy=1 in SEARCH, CONFIRM, LOCKED; otherwise 0.
REQ-031 lock_status holds its value until the next lock.
REQ-032 lock_valid and sweep_done are single-cycle pulses.

Reset
REQ-033 rst=1 forces, asynchronously: state=000, busy=0, corr_req=0, corr_sv_id=0, corr_doppler=0, lock_valid=0, lock_status=0, lock_count=0, sweep_done=0; watchdog, sv, bin and confirm counters cleared.
REQ-034 Reset mid-dwell abandons the dwell; after release, the block stays in IDLE until start.

Verification
REQ-035 start, correlator peak=0 always, ack immediately -> 32x21 dwells, Doppler sequence -5000, -4500 .. +5000 per SV, sweep_done pulse, state=100.
REQ-036 Peak 5000 at sv=3, bin=10, phase 511 on search and both confirms -> lock_valid with lock_status={6'd3, 16'd0, 10'd511}; next dwell sv=4, bin=0; end state IDLE, lock_count=1.
REQ-037 Search pass at phase 0, confirms at phase 1022 then 5 -> first confirm passes, second fails; resume at the next bin with no lock.
REQ-038 Ack delayed 7 cycles -> corr_req high 7 cycles with sv/Doppler stable; corr_done never arrives -> watchdog fail after 4096 cycles; sweep advances.
REQ-039 abort in the same cycle as start mid-CONFIRM -> IDLE next cycle, corr_req=0, lock_count unchanged.
REQ-040 rst asserted mid-dwell -> all outputs at reset values immediately, without waiting for a clock edge.
